// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit blocks.
//   rx_state_e         receiver FSM state encoding
//   PAR_EVEN/PAR_ODD   encodings of the PAR_TYP input
//   DATA_WIDTH_DEF     default number of data bits per frame (shared with TX)
package uart_pkg;

  localparam int   DATA_WIDTH_DEF = 8;
  localparam logic PAR_EVEN       = 1'b0;
  localparam logic PAR_ODD        = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit oversampling counter and 3-sample majority vote.
// Ports:
//   CLK, RST     clock, asynchronous active-low reset
//   en           count enable from the FSM (asserted for every cycle of a frame)
//   rx           serial line (already synchronous to CLK)
//   prescale     CLK cycles per bit (latched by the FSM at start detection)
//   sampled_bit  majority of the samples taken at P/2-1, P/2, P/2+1
//   bit_done     strobe on the last cycle of a bit (edge_cnt = P-1)
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic                  rx,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit,
  output logic                  bit_done
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last;
  logic [2:0]            samples;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  assign half = prescale >> 1;
  assign last = prescale - ONE;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      samples  <= '0;
    end else if (en) begin
      edge_cnt <= (edge_cnt == last) ? '0 : edge_cnt + ONE;
      if (edge_cnt == half - ONE) samples[0] <= rx;
      if (edge_cnt == half)       samples[1] <= rx;
      if (edge_cnt == half + ONE) samples[2] <= rx;
    end
  end

  // All three samples are registered well before P-1, so the vote is stable
  // on the completing edge.
  assign sampled_bit = majority3(samples);
  assign bit_done    = en && (edge_cnt == last);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receive deserializer.
// Detects the start bit, majority-votes each bit, assembles LSB-first data,
// optionally checks parity, checks the stop bit and presents the byte with
// a one-cycle Data_Valid pulse (or a one-cycle Par_Err/Stp_Err pulse).
// Ports:
//   CLK, RST    clock, asynchronous active-low reset
//   RX_IN       serial line, idle high
//   PAR_EN      frame carries a parity bit after the data bits
//   PAR_TYP     0 = even, 1 = odd parity
//   Prescale    CLK cycles per bit (8, 16 or 32)
//   P_DATA      received data
//   Data_Valid  pulse: P_DATA holds a new error-free frame
//   Par_Err     pulse: parity mismatch
//   Stp_Err     pulse: stop bit sampled 0
// Build option: define UART_RX_SYNC_EN to pass RX_IN through a 2-flop
// synchronizer (adds 2 cycles of latency from the pin).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);

  localparam int                CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  rx_state_e             state, next_state;
  logic                  rx_s;
  logic                  start_det;
  logic                  sampled_bit;
  logic                  bit_done;
  logic [PRESCALE_W-1:0] p_lat;
  logic                  par_en_l;
  logic                  par_typ_l;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_fail;
  logic                  stp_fail;
  logic                  frame_done;

`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rx_sync <= 2'b11;
    else      rx_sync <= {rx_sync[0], RX_IN};
  end

  assign rx_s = rx_sync[1];
`else
  assign rx_s = RX_IN;
`endif

  assign start_det = (state == IDLE) && !rx_s;

  // The start-detect edge is edge 0 of the start bit, so the sampler is
  // enabled on it and advances edge_cnt from 0 to 1.
  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .en          (start_det || (state != IDLE)),
    .rx          (rx_s),
    .prescale    (p_lat),
    .sampled_bit (sampled_bit),
    .bit_done    (bit_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!rx_s) next_state = START;
      START:   if (bit_done) next_state = sampled_bit ? IDLE : DATA;
      DATA:    if (bit_done && (bit_cnt == LAST_BIT))
                 next_state = par_en_l ? PARITY : STOP;
      PARITY:  if (bit_done) next_state = STOP;
      STOP:    if (bit_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Frame stage: latch configuration, assemble bits, record failures.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_lat      <= PRESCALE_W'(8);
      par_en_l   <= 1'b0;
      par_typ_l  <= PAR_EVEN;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_fail   <= 1'b0;
      stp_fail   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (start_det) begin
        p_lat     <= Prescale;
        par_en_l  <= PAR_EN;
        par_typ_l <= PAR_TYP;
        par_fail  <= 1'b0;
        stp_fail  <= 1'b0;
      end
      case (state)
        START:  if (bit_done) bit_cnt <= '0;
        DATA:   if (bit_done) begin
                  shift_reg[bit_cnt] <= sampled_bit;
                  bit_cnt            <= bit_cnt + CNT_W'(1);
                end
        PARITY: if (bit_done)
                  par_fail <= sampled_bit != ((^shift_reg) ^ (par_typ_l == PAR_ODD));
        STOP:   if (bit_done) begin
                  stp_fail   <= ~sampled_bit;
                  frame_done <= 1'b1;
                end
        default: ;
      endcase
    end
  end

  // Output stage: one cycle after the stop bit completes; the FSM is
  // already in IDLE and may be detecting the next start bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
      if (frame_done) begin
        if (!par_fail && !stp_fail) begin
          Data_Valid <= 1'b1;
          P_DATA     <= shift_reg;
        end else begin
          Par_Err <= par_fail;
          Stp_Err <= stp_fail;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int DW = 8;
  localparam int PW = 6;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [PW-1:0] Prescale;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          Par_Err;
  logic          Stp_Err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int       dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
  int       dv_cyc = 0, dv_cyc_prev = 0, se_cyc = 0, se_cyc_prev = 0;
  logic [7:0] dv_data = 8'h00, dv_data_prev = 8'h00;

  uart_rx #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Par_Err    (Par_Err),
    .Stp_Err    (Stp_Err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge CLK) begin
    if (Data_Valid === 1'b1) begin
      dv_cnt++;
      dv_cyc_prev  = dv_cyc;
      dv_cyc       = cyc;
      dv_data_prev = dv_data;
      dv_data      = P_DATA;
    end
    if (Par_Err === 1'b1) pe_cnt++;
    if (Stp_Err === 1'b1) begin
      se_cnt++;
      se_cyc_prev = se_cyc;
      se_cyc      = cyc;
    end
  end

  task automatic send_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(negedge CLK);
  endtask

  // Called on a negedge; t0 = cycle count at the moment RX_IN drops.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                            input logic ptyp, input logic pbit, input logic sbit,
                            input bit scramble, output int t0);
    Prescale = PW'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    t0       = cyc;
    send_bit(1'b0, p);
    if (scramble) begin
      Prescale = PW'((p == 8) ? 32 : 8);
      PAR_EN   = ~pen;
      PAR_TYP  = ~ptyp;
    end
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (pen) send_bit(pbit, p);
    send_bit(sbit, p);
    RX_IN = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL reset_p_data: got %0h expected 0", P_DATA); end
    checks++; if (Data_Valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b expected 0", Data_Valid); end
    checks++; if (Par_Err !== 1'b0) begin errors++; $display("FAIL reset_par_err: got %b expected 0", Par_Err); end
    checks++; if (Stp_Err !== 1'b0) begin errors++; $display("FAIL reset_stp_err: got %b expected 0", Stp_Err); end
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (dv_cnt + pe_cnt + se_cnt != 0) begin errors++; $display("FAIL idle_pulses: got %0d expected 0", dv_cnt + pe_cnt + se_cnt); end
  endtask

  task automatic test_basic();
    int t0;
    int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    repeat (3) @(negedge CLK);
    checks++; if (dv_cnt != dv0 + 1) begin errors++; $display("FAIL basic_dv_count: got %0d expected %0d", dv_cnt, dv0 + 1); end
    checks++; if (dv_data !== 8'hA5) begin errors++; $display("FAIL basic_dv_data: got %0h expected a5", dv_data); end
    checks++; if (P_DATA !== 8'hA5) begin errors++; $display("FAIL basic_p_data: got %0h expected a5", P_DATA); end
    checks++; if (dv_cyc != t0 + 1 + 80 + SYNC_LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", dv_cyc - t0 - 1, 80 + SYNC_LAT); end
    checks++; if (pe_cnt != pe0 || se_cnt != se0) begin errors++; $display("FAIL basic_errs: got pe=%0d se=%0d expected pe=%0d se=%0d", pe_cnt, se_cnt, pe0, se0); end
  endtask

  task automatic test_parity();
    int t0;
    int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
    // Good even parity; configuration inputs scrambled mid-frame.
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, t0);
    repeat (3) @(negedge CLK);
    checks++; if (dv_cnt != dv0 + 1) begin errors++; $display("FAIL par_ok_dv_count: got %0d expected %0d", dv_cnt, dv0 + 1); end
    checks++; if (P_DATA !== 8'h3C) begin errors++; $display("FAIL par_ok_p_data: got %0h expected 3c", P_DATA); end
    checks++; if (dv_cyc != t0 + 1 + 16 * 11 + SYNC_LAT) begin errors++; $display("FAIL par_ok_latency: got %0d expected %0d", dv_cyc - t0 - 1, 176 + SYNC_LAT); end
    checks++; if (pe_cnt != pe0) begin errors++; $display("FAIL par_ok_pe: got %0d expected %0d", pe_cnt, pe0); end
    // Bad parity bit.
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, t0);
    repeat (3) @(negedge CLK);
    checks++; if (pe_cnt != pe0 + 1) begin errors++; $display("FAIL par_bad_pe: got %0d expected %0d", pe_cnt, pe0 + 1); end
    checks++; if (dv_cnt != dv0 + 1) begin errors++; $display("FAIL par_bad_dv: got %0d expected %0d", dv_cnt, dv0 + 1); end
    checks++; if (P_DATA !== 8'h3C) begin errors++; $display("FAIL par_bad_p_data: got %0h expected 3c", P_DATA); end
    checks++; if (se_cnt != se0) begin errors++; $display("FAIL par_bad_se: got %0d expected %0d", se_cnt, se0); end
  endtask

  task automatic test_stop_err();
    int t0;
    int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
    send_frame(8'h01, 32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, t0);
    repeat (3) @(negedge CLK);
    checks++; if (se_cnt != se0 + 1) begin errors++; $display("FAIL stop_se: got %0d expected %0d", se_cnt, se0 + 1); end
    checks++; if (se_cyc != t0 + 1 + 32 * 11 + SYNC_LAT) begin errors++; $display("FAIL stop_latency: got %0d expected %0d", se_cyc - t0 - 1, 352 + SYNC_LAT); end
    checks++; if (pe_cnt != pe0) begin errors++; $display("FAIL stop_pe: got %0d expected %0d", pe_cnt, pe0); end
    checks++; if (dv_cnt != dv0) begin errors++; $display("FAIL stop_dv: got %0d expected %0d", dv_cnt, dv0); end
    checks++; if (P_DATA !== 8'h3C) begin errors++; $display("FAIL stop_p_data: got %0h expected 3c", P_DATA); end
  endtask

  task automatic test_glitch();
    int t0;
    int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
    Prescale = PW'(16);
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (40) @(negedge CLK);
    checks++; if (dv_cnt != dv0 || pe_cnt != pe0 || se_cnt != se0) begin errors++; $display("FAIL glitch_pulses: got dv=%0d pe=%0d se=%0d expected %0d %0d %0d", dv_cnt, pe_cnt, se_cnt, dv0, pe0, se0); end
    checks++; if (P_DATA !== 8'h3C) begin errors++; $display("FAIL glitch_p_data: got %0h expected 3c", P_DATA); end
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    repeat (3) @(negedge CLK);
    checks++; if (dv_cnt != dv0 + 1 || dv_data !== 8'h5A) begin errors++; $display("FAIL glitch_recover: got dv=%0d data=%0h expected %0d 5a", dv_cnt, dv_data, dv0 + 1); end
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    int dv0 = dv_cnt, se0 = se_cnt;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t1);
    repeat (3) @(negedge CLK);
    checks++; if (dv_cnt != dv0 + 2) begin errors++; $display("FAIL b2b_dv_count: got %0d expected %0d", dv_cnt, dv0 + 2); end
    checks++; if (dv_data_prev !== 8'h55) begin errors++; $display("FAIL b2b_first: got %0h expected 55", dv_data_prev); end
    checks++; if (dv_data !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %0h expected ff", dv_data); end
    checks++; if (dv_cyc - dv_cyc_prev != 80) begin errors++; $display("FAIL b2b_spacing: got %0d expected 80", dv_cyc - dv_cyc_prev); end
    checks++; if (dv_cyc_prev != t0 + 1 + 80 + SYNC_LAT) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", dv_cyc_prev - t0 - 1, 80 + SYNC_LAT); end
    checks++; if (se_cnt != se0) begin errors++; $display("FAIL b2b_se: got %0d expected %0d", se_cnt, se0); end
  endtask

  task automatic test_reset_mid();
    int t0;
    logic [7:0] d = 8'h3C;
    int dv0, pe0, se0;
    Prescale = PW'(8);
    PAR_EN   = 1'b0;
    send_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) send_bit(d[i], 8);
    RX_IN = d[4];
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL midrst_p_data: got %0h expected 0", P_DATA); end
    checks++; if ({Data_Valid, Par_Err, Stp_Err} !== 3'b000) begin errors++; $display("FAIL midrst_pulses: got %b expected 000", {Data_Valid, Par_Err, Stp_Err}); end
    repeat (4) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if ({P_DATA, Data_Valid, Par_Err, Stp_Err} !== 11'd0) begin errors++; $display("FAIL midrst_hold: got %0h expected 0", {P_DATA, Data_Valid, Par_Err, Stp_Err}); end
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    repeat (3) @(negedge CLK);
    checks++; if (dv_cnt != dv0 + 1 || P_DATA !== 8'h81) begin errors++; $display("FAIL midrst_recover: got dv=%0d data=%0h expected %0d 81", dv_cnt, P_DATA, dv0 + 1); end
    checks++; if (dv_cyc != t0 + 1 + 80 + SYNC_LAT) begin errors++; $display("FAIL midrst_latency: got %0d expected %0d", dv_cyc - t0 - 1, 80 + SYNC_LAT); end
    checks++; if (pe_cnt != pe0 || se_cnt != se0) begin errors++; $display("FAIL midrst_errs: got pe=%0d se=%0d expected %0d %0d", pe_cnt, se_cnt, pe0, se0); end
  endtask

  task automatic test_stuck_low();
    int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
    Prescale = PW'(8);
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    // Two full frames plus the restart edge of a third, which then glitches out.
    repeat (161) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (20) @(negedge CLK);
    checks++; if (se_cnt != se0 + 2) begin errors++; $display("FAIL stuck_se: got %0d expected %0d", se_cnt, se0 + 2); end
    checks++; if (se_cyc - se_cyc_prev != 80) begin errors++; $display("FAIL stuck_spacing: got %0d expected 80", se_cyc - se_cyc_prev); end
    checks++; if (dv_cnt != dv0 || pe_cnt != pe0) begin errors++; $display("FAIL stuck_other: got dv=%0d pe=%0d expected %0d %0d", dv_cnt, pe_cnt, dv0, pe0); end
    checks++; if (P_DATA !== 8'h81) begin errors++; $display("FAIL stuck_p_data: got %0h expected 81", P_DATA); end
  endtask

  initial begin
    RST      = 1'b0;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    Prescale = PW'(8);
    test_reset();
    test_basic();
    test_parity();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_stuck_low();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive deserializer. It is the receive-side counterpart of the UART TX serializer.
- Oversamples the serial line at Prescale CLK cycles per bit.
- Detects the start bit, majority-votes each bit and assembles LSB-first data.
- Optionally checks parity and checks the stop bit.
- Presents the parallel byte with a one-cycle valid pulse to the downstream consumer.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_W, 6, width of Prescale input; legal Prescale values are 8, 16, 32

Ports:
CLK  input  1  clock
RST  input  1  asynchronous reset, active-low
RX_IN  input  1  serial line, idle high
PAR_EN  input  1  1 = frame carries a parity bit after the data bits
PAR_TYP  input  1  0 = even, 1 = odd parity
Prescale  input  PRESCALE_W  CLK cycles per bit (oversampling ratio)
P_DATA  output  DATA_WIDTH  received data, LSB first on line
Data_Valid  output  1  one-cycle pulse: P_DATA holds a new, error-free frame
Par_Err  output  1  one-cycle pulse: parity mismatch in the completed frame
Stp_Err  output  1  one-cycle pulse: stop bit sampled 0

Behaviour:
- Reset (RST low, any time including mid-frame):
  - FSM to IDLE; counters and shift register cleared.
  - P_DATA=0, Data_Valid=0, Par_Err=0, Stp_Err=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - edge_cnt counts 0..P-1 within each bit, where P is Prescale latched on start detection.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
  - Changes to Prescale, PAR_EN or PAR_TYP mid-frame have no effect on the current frame (all are latched at start detection).
- IDLE:
  - A CLK edge with RX_IN=0 is edge 0 of the start bit: go to START with edge_cnt=1.
  - Latch Prescale, PAR_EN and PAR_TYP on this edge.
- Sampling:
  - In every bit, RX_IN is sampled at edge_cnt = P/2-1, P/2 and P/2+1.
  - Bit value = majority of the 3 samples.
  - Bit completes at edge_cnt = P-1; edge_cnt then wraps to 0.
- START: at bit completion:
  - Voted value 1 = glitch: return to IDLE, no output activity, no error.
  - Voted value 0: go to DATA with bit_cnt=0.
- DATA:
  - Each completed bit shifts into the shift register at position bit_cnt (LSB first).
  - After bit DATA_WIDTH-1: go to PARITY if PAR_EN, else STOP.
- PARITY:
  - Expected bit = XOR of data bits, inverted when PAR_TYP=1.
  - Mismatch sets an internal par_fail flag; go to STOP.
- STOP, on the completing edge:
  - Voted 0 sets stp_fail.
  - Go to IDLE.
  - The next cycle drives exactly one of these outcomes:
    - No fails: Data_Valid=1 and P_DATA=shift register (same edge).
    - Any fail: Par_Err=par_fail, Stp_Err=stp_fail, and P_DATA holds its previous value.
- Outputs are registered; pulses last exactly one CLK.
- Frame latency: start detect to Data_Valid = P*(2+DATA_WIDTH+PAR_EN) CLK cycles.
- Back-to-back frames:
  - IDLE may detect the next start bit on the same cycle the pulses are high.
  - No dead cycle is required beyond the return to IDLE.
- RX_IN held low permanently:
  - Each frame ends with Stp_Err.
  - The receiver re-enters START on the next cycle and repeats.

Optional Feature:
UART_RX_SYNC_EN
- Defined: RX_IN passes through a 2-flop synchronizer (reset value 1) before all logic. Start detect and all sample points shift 2 CLK later, so latency measured from the RX_IN pin grows by 2 cycles.
- Undefined: RX_IN is used directly and must already be synchronous to CLK.

Decomposition:
- Shared package uart_pkg:
  - enum rx_state_e {IDLE, START, DATA, PARITY, STOP}.
  - Parity constants PAR_EVEN=1'b0, PAR_ODD=1'b1.
  - Default DATA_WIDTH, shared with the TX side.
- Sub-module uart_rx_sampler:
  - Holds edge_cnt and the 3-sample majority vote.
  - Outputs sampled_bit and bit_done strobe; inputs Prescale and an enable from the FSM.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 with stop=1 -> after 80 cycles P_DATA=0xA5, Data_Valid high for 1 cycle, no errors.
- Prescale=16, PAR_EN=1, PAR_TYP=0, frame 0x3C with parity bit 0 -> P_DATA=0x3C, Data_Valid. Same frame with parity bit 1 -> Par_Err pulse, Data_Valid stays 0, P_DATA unchanged.
- Prescale=32, PAR_TYP=1, frame 0x01 with stop bit driven 0 -> Stp_Err pulse (Par_Err=0 when parity bit=0), no Data_Valid.
- Prescale=16, RX_IN low for only 3 cycles then high -> FSM returns to IDLE after start bit, no outputs pulse.
- Two back-to-back frames 0x55 then 0xFF at Prescale=8 with no idle gap -> two Data_Valid pulses 80 cycles apart, P_DATA=0x55 then 0xFF.
- RST asserted during DATA bit 4, released, then full frame 0x81 -> all outputs 0 during reset, clean reception of 0x81 afterwards.
